// File: rtl/vision_grid_detect.sv
// Dark-marker grid detector: classifies RGB565 pixels, counts markers per grid cell,
// then thresholds and debounces each cell at end of frame to drive lane/jump outputs.
module vision_grid_detect #(
  parameter int FRAME_WIDTH     = 320,
  parameter int FRAME_HEIGHT    = 240,
  parameter int GRID_COLS       = 3,
  parameter int GRID_ROWS       = 3,
  parameter int COUNT_THRESHOLD = 64,
  parameter int PERSIST_FRAMES  = 2,
  parameter int DARK_MAX_RB     = 4,
  parameter int DARK_MAX_G      = 8
) (
  input  logic                           pixel_clock_in,
  input  logic                           reset_in,
  input  logic [9:0]                     frame_x_count,
  input  logic [8:0]                     frame_y_count,
  input  logic [15:0]                    pixel_data,
  input  logic                           pixel_valid,
  output logic [GRID_ROWS*GRID_COLS-1:0] quadrants,
  output logic [$clog2(GRID_COLS)-1:0]   lane,
  output logic                           jump,
  output logic                           data_valid
);
  localparam int NCELL = GRID_ROWS * GRID_COLS;
  localparam int CW    = $clog2(GRID_COLS);
  localparam int IW    = $clog2(NCELL);
  localparam int CNTW  = $clog2(FRAME_WIDTH * FRAME_HEIGHT + 1);
  localparam int LROW  = (GRID_ROWS - 1) * GRID_COLS;

  typedef enum logic {S_WAIT_SOF, S_ACCUM} state_t;

  logic          r_i_vld;
  logic [9:0]    r_i_x;
  logic [8:0]    r_i_y;
  logic [15:0]   r_i_pix;

  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) begin
      r_i_vld <= 1'b0;
      r_i_x   <= '0;
      r_i_y   <= '0;
      r_i_pix <= '0;
    end else begin
      r_i_vld <= pixel_valid;
      r_i_x   <= frame_x_count;
      r_i_y   <= frame_y_count;
      r_i_pix <= pixel_data;
    end
  end

  // Cell index by counting crossed boundaries: avoids a divider on the pixel path.
  logic          w_inr, w_mark, w_sof, w_eof;
  logic [IW-1:0] w_idx;
  int            w_col, w_row;

  always_comb begin
    w_col = 0;
    w_row = 0;
    for (int c = 1; c < GRID_COLS; c++)
      if (32'(r_i_x) * GRID_COLS >= c * FRAME_WIDTH) w_col = w_col + 1;
    for (int r = 1; r < GRID_ROWS; r++)
      if (32'(r_i_y) * GRID_ROWS >= r * FRAME_HEIGHT) w_row = w_row + 1;
    w_idx  = IW'(w_row * GRID_COLS + w_col);
    w_inr  = (32'(r_i_x) < FRAME_WIDTH) && (32'(r_i_y) < FRAME_HEIGHT);
    w_mark = (32'(r_i_pix[15:11]) <= DARK_MAX_RB) && (32'(r_i_pix[10:5]) <= DARK_MAX_G) &&
             (32'(r_i_pix[4:0]) <= DARK_MAX_RB);
    w_sof  = (r_i_x == '0) && (r_i_y == '0);
    w_eof  = (32'(r_i_x) == FRAME_WIDTH - 1) && (32'(r_i_y) == FRAME_HEIGHT - 1);
  end

  logic          r_d_vld, r_d_mark, r_d_sof, r_d_eof;
  logic [IW-1:0] r_d_idx;

  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) begin
      r_d_vld  <= 1'b0;
      r_d_mark <= 1'b0;
      r_d_sof  <= 1'b0;
      r_d_eof  <= 1'b0;
      r_d_idx  <= '0;
    end else begin
      r_d_vld  <= r_i_vld & w_inr;
      r_d_mark <= w_mark;
      r_d_sof  <= w_sof;
      r_d_eof  <= w_eof;
      r_d_idx  <= w_idx;
    end
  end

  state_t r_state, w_state_nxt;
  logic   w_clr, w_inc, w_eof_hit;
  logic   r_eval;

  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) r_state <= S_WAIT_SOF;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    w_eof_hit   = 1'b0;
    case (r_state)
      S_WAIT_SOF: if (r_d_vld && r_d_sof) begin
        w_clr       = 1'b1;
        w_inc       = 1'b1;
        w_state_nxt = S_ACCUM;
      end
      S_ACCUM: if (r_d_vld) begin
        w_inc     = 1'b1;
        w_clr     = r_d_sof;
        w_eof_hit = r_d_eof;
      end
      default: w_state_nxt = S_WAIT_SOF;
    endcase
  end

  logic [CNTW-1:0]  r_cnt [NCELL];
  logic [NCELL-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NCELL; i++)
      w_hit[i] = w_inc && r_d_mark && (r_d_idx == IW'(i));
  end

  // A clear (restart or evaluation) coincident with a new pixel loads that pixel's count.
  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) begin
      for (int i = 0; i < NCELL; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCELL; i++) begin
        if (w_clr || r_eval) r_cnt[i] <= CNTW'(w_hit[i]);
        else if (w_hit[i])   r_cnt[i] <= r_cnt[i] + CNTW'(1);
      end
    end
  end

  logic [3:0]       r_streak [NCELL];
  logic [3:0]       w_streak_nxt [NCELL];
  logic [NCELL-1:0] w_raw, w_stable;
  logic [NCELL-1:0] r_quad;
  logic [CW-1:0]    r_lane, w_lane;
  logic             r_jump, r_dv;

  always_comb begin
    w_raw    = '0;
    w_stable = '0;
    for (int i = 0; i < NCELL; i++) begin
      w_raw[i]        = 32'(r_cnt[i]) >= COUNT_THRESHOLD;
      w_streak_nxt[i] = !w_raw[i] ? 4'd0 : (r_streak[i] == 4'hF ? 4'hF : r_streak[i] + 4'd1);
      w_stable[i]     = w_raw[i] && (32'(w_streak_nxt[i]) >= PERSIST_FRAMES);
    end
    w_lane = r_lane;
    for (int c = GRID_COLS - 1; c >= 0; c--)
      if (w_stable[LROW + c]) w_lane = CW'(c);
  end

  always_ff @(posedge pixel_clock_in) begin
    if (reset_in) begin
      r_eval <= 1'b0;
      r_dv   <= 1'b0;
      r_quad <= '0;
      r_lane <= CW'(GRID_COLS / 2);
      r_jump <= 1'b0;
      for (int i = 0; i < NCELL; i++) r_streak[i] <= '0;
    end else begin
      r_eval <= w_eof_hit;
      r_dv   <= r_eval;
      if (r_eval) begin
        r_quad <= w_stable;
        r_lane <= w_lane;
        r_jump <= |w_stable[GRID_COLS-1:0];
        for (int i = 0; i < NCELL; i++) r_streak[i] <= w_streak_nxt[i];
      end
    end
  end

  assign quadrants  = r_quad;
  assign lane       = r_lane;
  assign jump       = r_jump;
  assign data_valid = r_dv;
endmodule

// File: tb/tb_vision_grid_detect.sv
// Randomized scoreboard bench for vision_grid_detect on a 16x12 frame, 3x3 grid.
module tb_vision_grid_detect;
  localparam int W = 16, H = 12, C = 3, R = 3, TH = 2, PF = 2, NC = 9;

  logic        clk = 1'b0, rst = 1'b1;
  logic [9:0]  fx = '0;
  logic [8:0]  fy = '0;
  logic [15:0] pd = '0;
  logic        pv = 1'b0;
  logic [8:0]  q;
  logic [1:0]  ln;
  logic        jp, dv;
  bit          done = 1'b0;
  longint      cyc = 0;

  vision_grid_detect #(
    .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .GRID_COLS(C), .GRID_ROWS(R),
    .COUNT_THRESHOLD(TH), .PERSIST_FRAMES(PF), .DARK_MAX_RB(4), .DARK_MAX_G(8)
  ) dut (
    .pixel_clock_in(clk), .reset_in(rst), .frame_x_count(fx), .frame_y_count(fy),
    .pixel_data(pd), .pixel_valid(pv), .quadrants(q), .lane(ln), .jump(jp), .data_valid(dv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [8:0] q; int lane; bit jump; longint at;} exp_t;
  exp_t sb[$];

  // Reference model: per-frame marker tallies with plain division for cell mapping.
  bit m_acc;
  int m_cnt[NC];
  int m_streak[NC];
  int m_lane;

  function automatic bit is_mark(logic [15:0] p);
    return p[15:11] <= 5'd4 && p[10:5] <= 6'd8 && p[4:0] <= 5'd4;
  endfunction

  task automatic m_reset();
    m_acc = 0;
    m_lane = C / 2;
    for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_streak[i] = 0; end
  endtask

  task automatic m_eval(longint at);
    exp_t e;
    e.q = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_cnt[i] >= TH) m_streak[i] = (m_streak[i] < 15) ? m_streak[i] + 1 : 15;
      else                m_streak[i] = 0;
      e.q[i] = (m_cnt[i] >= TH) && (m_streak[i] >= PF);
      m_cnt[i] = 0;
    end
    for (int c = 0; c < C; c++)
      if (e.q[(R-1)*C + c]) begin m_lane = c; break; end
    e.lane = m_lane;
    e.jump = e.q[0] | e.q[1] | e.q[2];
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drive(int x, int y, logic [15:0] p, bit v);
    @(posedge clk); #1;
    fx = 10'(x); fy = 9'(y); pd = p; pv = v;
    if (v && x < W && y < H) begin
      if (x == 0 && y == 0) begin
        m_acc = 1;
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      end
      if (m_acc) begin
        if (is_mark(p)) m_cnt[(y * R / H) * C + x * C / W]++;
        if (x == W-1 && y == H-1) m_eval(cyc + 4);
      end
    end
  endtask

  function automatic logic [15:0] dark_px();
    return {5'($urandom_range(0, 4)), 6'($urandom_range(0, 8)), 5'($urandom_range(0, 4))};
  endfunction

  function automatic logic [15:0] light_px();
    logic [15:0] p;
    case ($urandom_range(0, 3))
      0: p = 16'h07E0;
      1: p = {5'd5, 6'd0, 5'd0};
      2: p = {5'd0, 6'd9, 5'd4};
      default: begin p = 16'($urandom); if (is_mark(p)) p = p | 16'h8000; end
    endcase
    return p;
  endfunction

  function automatic bit is_pat(int x, int y);
    return (x >= 6 && x <= 8 && y <= 1) || (x == 14 && y == 3) || (x == 3 && y == 9) ||
           (x >= 13 && y == 10) || (y == 11 && (x == 13 || x == 15));
  endfunction

  task automatic junk();
    if ($urandom_range(0, 9) == 0)
      drive($urandom_range(0, 1) ? W + $urandom_range(0, 1000) : $urandom_range(0, W-1),
            H + $urandom_range(0, 499), dark_px(), 1);
    else
      drive($urandom_range(0, 1) ? 0 : $urandom_range(0, 1023),
            $urandom_range(0, 1) ? 0 : $urandom_range(0, 511), dark_px(), 0);
  endtask

  task automatic idle(int n);
    repeat (n) drive($urandom_range(0, 1023), $urandom_range(0, 511), 16'($urandom), 0);
  endtask

  // mode: 0 random, 1 test pattern, 2 all green, 3 random with dark (0,0). gap: 0 none, 1 alternate, 2 random.
  task automatic frame(int mode, int gap, int abort_line, int start);
    bit d;
    for (int i = start; i < W*H; i++) begin
      int x, y;
      x = i % W; y = i / W;
      if (abort_line >= 0 && y == abort_line) break;
      if (gap == 1) junk();
      else if (gap == 2) while ($urandom_range(0, 99) < 30) junk();
      case (mode)
        1: d = is_pat(x, y);
        2: d = 0;
        3: d = (i == 0) || ($urandom_range(0, 99) < 12);
        default: d = $urandom_range(0, 99) < 12;
      endcase
      drive(x, y, d ? dark_px() : ((mode == 1 || mode == 2) ? 16'h07E0 : light_px()), 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; pv = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(3);
    frame(1, 0, -1, 0);
    frame(1, 0, -1, 0);
    idle(2);
    frame(2, 2, -1, 0);
    frame(1, 0, -1, 0);
    idle(4);
    frame(1, 0, 5, 0);
    frame(1, 2, -1, 0);
    idle(6);
    frame(1, 0, 6, 0);
    do_reset();
    frame(1, 0, -1, 2*W + 4);
    idle(3);
    frame(1, 0, -1, 0);
    frame(1, 1, -1, 0);
    idle(5);
    repeat (17) frame(1, 0, -1, 0);
    repeat (6) frame(3, 0, -1, 0);
    repeat (3) frame(3, 1, -1, 0);
    for (int k = 0; k < 12; k++)
      frame($urandom_range(0, 3), 2, ($urandom_range(0, 4) == 0) ? $urandom_range(0, H-1) : -1, 0);
    idle(10);
    done = 1;
  end

  int errors = 0, checks = 0;

  function automatic void chk(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  initial begin
    bit         prev_rst;
    logic [8:0] hq;
    int         hl;
    bit         hj;
    exp_t       e;
    prev_rst = 1; hq = '0; hl = C / 2; hj = 0;
    forever begin
      @(negedge clk);
      if (cyc > 60000) begin
        $display("FAIL watchdog: got cycle %0d, required below 60000", cyc);
        $fatal(1, "watchdog");
      end
      if (rst) begin
        hq = '0; hl = C / 2; hj = 0; prev_rst = 1;
      end else begin
        if (prev_rst) begin
          chk("reset_quadrants", q, 0);
          chk("reset_lane", ln, 1);
          chk("reset_jump", jp, 0);
          chk("reset_data_valid", dv, 0);
          prev_rst = 0;
        end else if (dv) begin
          if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            e = sb.pop_front();
            chk("quadrants", q, e.q);
            chk("lane", ln, e.lane);
            chk("jump", jp, e.jump);
            chk("strobe_cycle", cyc, e.at);
            hq = e.q; hl = e.lane; hj = e.jump;
          end
        end else begin
          chk("hold_outputs", {q, ln, jp}, {hq, 2'(hl), hj});
        end
      end
      if (done) begin
        chk("pending_strobes", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end
endmodule

// File: doc/vision_grid_detect.md
# vision_grid_detect

Parametrised successor to the fixed 3x3 vision stage. It classifies each streamed RGB565 camera pixel as marker or background and accumulates marker counts per cell of a configurable GRID_ROWS x GRID_COLS grid. At end of frame it thresholds the counts and debounces each cell across consecutive frames. It then publishes a cell bitmap, a lane index and a jump flag to the game logic. It sits directly after camera capture in the pixel_clock_in domain.

## Interface
- FRAME_WIDTH, 320, active pixels per line
- FRAME_HEIGHT, 240, active lines per frame
- GRID_COLS, 3, grid columns (2..8)
- GRID_ROWS, 3, grid rows (1..8)
- COUNT_THRESHOLD, 64, minimum marker pixels for a cell to be raw-set in a frame
- PERSIST_FRAMES, 2, consecutive raw-set frames before a cell is stable (1..15)
- DARK_MAX_RB, 4, max R5 and B5 for a marker pixel
- DARK_MAX_G, 8, max G6 for a marker pixel
- pixel_clock_in  in  1  sole clock, all logic on rising edge
- reset_in  in  1  synchronous, active-high
- frame_x_count  in  10  pixel column
- frame_y_count  in  9  pixel row
- pixel_data  in  16  RGB565 {R5,G6,B5}
- pixel_valid  in  1  pixel/coords valid this cycle
- quadrants  out  GRID_ROWS*GRID_COLS  stable bitmap, bit = row*GRID_COLS+col
- lane  out  $clog2(GRID_COLS)  lane index
- jump  out  1  any stable cell in row 0
- data_valid  out  1  one-cycle strobe when outputs update

## Operation
- Marker: R5<=DARK_MAX_RB && G6<=DARK_MAX_G && B5<=DARK_MAX_RB.
- Cell mapping: col = (x*GRID_COLS)/FRAME_WIDTH, row = (y*GRID_ROWS)/FRAME_HEIGHT, integer floor. For 16x12 on 3x3: cols x0-5/6-10/11-15, rows y0-3/4-7/8-11.
- Pixels with x>=FRAME_WIDTH or y>=FRAME_HEIGHT are ignored.
- Pixels with pixel_valid=0 are ignored.
- Per-cell counters are $clog2(FRAME_WIDTH*FRAME_HEIGHT+1) bits wide and cannot overflow.
- FSM WAIT_SOF: ignore pixels until a valid pixel at (0,0). That pixel clears all counters, is itself counted, and moves the FSM to ACCUM.
- FSM ACCUM: count markers. On a valid pixel at (FRAME_WIDTH-1, FRAME_HEIGHT-1) (EOF), run end-of-frame processing and stay in ACCUM.
- A valid (0,0) pixel in ACCUM before EOF aborts the frame. Counters restart from that pixel. No output update and no data_valid.
- End-of-frame, per cell:
  - raw = count >= COUNT_THRESHOLD.
  - streak (4-bit) = raw ? min(streak+1, 15) : 0.
  - stable = raw && (new streak >= PERSIST_FRAMES).
  - quadrants <= stable bitmap.
  - Counters cleared.
- lane: lowest col with a stable bit in row GRID_ROWS-1. If that row has no stable cell, lane holds its previous value.
- jump: OR of stable bits in row 0. Updated every EOF.
- Reset values: quadrants=0, lane=GRID_COLS/2, jump=0, data_valid=0, all counters and streaks 0, FSM=WAIT_SOF.
- Reset mid-frame discards the partial frame. Streak history is cleared.

## Timing
- Pipeline: input register, then counter update, then evaluation.
- A pixel sampled at edge N is reflected in its counter after edge N+2.
- EOF sampled at edge N: quadrants, lane and jump change at edge N+3. data_valid is high for cycle N+3 only.
- Outputs hold between strobes.
- Counter clear at EOF evaluation coincident with an increment from a new pixel: counter loads 1 (marker) or 0 (non-marker). The new pixel is never lost or double-counted.
- Back-to-back valid pixels (every cycle) are supported at full rate. Valid every other cycle is also supported.
- reset_in dominates every other event in the same cycle.

## Test plan
- 16x12, 3x3, COUNT_THRESHOLD=2, PERSIST_FRAMES=2. Frame: black at (6..8, 0..1), (14,3), (3,9), (13..15,10), (13,11), (15,11); rest green 0x07E0. First frame -> data_valid once, quadrants=0x000, lane=1, jump=0.
- Same frame repeated -> quadrants=0x102, lane=2, jump=1. data_valid lands exactly 3 cycles after the EOF pixel edge.
- All-green third frame -> quadrants=0x000, jump=0, lane holds 2. Streaks are zeroed, so a fourth marked frame gives 0x000 again.
- Frame restarted at (0,0) after 5 lines -> no data_valid for the aborted frame. The next full marked frame counts only from the restart.
- reset_in asserted mid-frame, then pixels sent from (4,2) onward -> ignored until (0,0). All outputs stay at reset values (lane=1) until the first full-frame strobe.
- Valid every cycle, with the next frame's (0,0) marker pixel arriving 1 cycle after EOF -> previous frame's quadrants correct. That pixel's cell count for the new frame is 1.
